mem_port_arbiter: RTL

//  Shares the single 64-bit memory port between the instruction fetcher (read-only prefetch of
//  64-bit lines) and the load/store unit (reads/writes with byte enables). One access in flight.

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//  Shares one 64-bit memory port between the instruction fetcher (read-only
//  line prefetch) and the load/store unit (reads/writes with byte enables).
//  One access is in flight at a time. Data wins arbitration, but a streak
//  counter bounds how many data grants in a row can starve a pending fetch.
//  A fetch flush suppresses the fetch response without aborting the bus
//  transaction.
//
//  Ports
//   clk, reset                  clock, asynchronous active-low reset
//   if_req/if_addr/flush        fetch request, word address, redirect flush
//   if_valid/if_rdata           fetch response pulse and line
//   ls_req/ls_we/ls_addr/ls_be/ls_wdata   load/store request
//   ls_valid/ls_rdata           load/store completion pulse and read data
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata   bus request (held until ack)
//   mem_ack/mem_rdata           bus completion and read data
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int unsigned ADDR_W          = 23,
   parameter int unsigned MAX_DATA_STREAK = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              flush,
   output logic              if_valid,
   output logic [63:0]       if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [7:0]        ls_be,
   input  logic [63:0]       ls_wdata,
   output logic              ls_valid,
   output logic [63:0]       ls_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_be,
   output logic [63:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [63:0]       mem_rdata
);

   localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DATA  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t              state;
   logic [STREAK_W-1:0] streak;
   logic                discard;
   logic                grant_data_c;

   // Data wins unless a waiting fetch has already lost MAX_DATA_STREAK times in a row
   assign grant_data_c = ls_req && (!if_req || (streak < STREAK_MAX));

   // Arbitration FSM; every output is a register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         streak    <= '0;
         discard   <= 1'b0;
         if_valid  <= 1'b0;
         if_rdata  <= '0;
         ls_valid  <= 1'b0;
         ls_rdata  <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
      end else begin
         if_valid <= 1'b0;
         ls_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant_data_c) begin
                  state     <= S_DATA;
                  mem_req   <= 1'b1;
                  mem_we    <= ls_we;
                  mem_addr  <= ls_addr;
                  mem_be    <= ls_we ? ls_be : 8'hFF;
                  mem_wdata <= ls_wdata;
                  // streak only counts data wins that made a fetch wait
                  if (!if_req)
                     streak <= '0;
                  else if (streak != STREAK_MAX)
                     streak <= streak + STREAK_W'(1);
               end else if (if_req) begin
                  state     <= S_FETCH;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= if_addr;
                  mem_be    <= 8'hFF;
                  mem_wdata <= '0;
                  streak    <= '0;
               end
            end
            S_FETCH: begin
               if (flush)
                  discard <= 1'b1;
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  state   <= S_RESP;
                  // flush on the ack cycle still kills the response
                  if (!(discard || flush)) begin
                     if_valid <= 1'b1;
                     if_rdata <= mem_rdata;
                  end
               end
            end
            S_DATA: begin
               if (mem_ack) begin
                  mem_req  <= 1'b0;
                  state    <= S_RESP;
                  ls_valid <= 1'b1;
                  if (!mem_we)
                     ls_rdata <= mem_rdata;
               end
            end
            S_RESP: begin
               // requester drops its request at this edge, so no arbitration here
               state   <= S_IDLE;
               discard <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
